serial_duty_receiver: RTL

//  Serial frame receiver for multi-channel PWM duty values, clocked by the external data clock.

---
 rtl/serial_duty_receiver_if.sv | 41 ++++
 rtl/serial_duty_receiver.sv | 130 +++++++++++++
 2 files changed

// File: rtl/serial_duty_receiver_if.sv
// Serial duty frame bus: serial input side plus the parallel duty/status side.
// The master drives the serial gate and data, the slave is the receiver.
interface serial_duty_receiver_if #(
    parameter int CHANNELS = 3,
    parameter int DUTY_W   = 10,
    parameter int ADDR_W   = 4
);
    localparam int FRAME_LEN = ADDR_W + 2 + CHANNELS * DUTY_W + 1;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    logic                       data_en;
    logic                       data;
    logic [CHANNELS*DUTY_W-1:0] duty;
    logic                       out_en;
    logic                       frame_ok;
    logic                       err_parity;
    logic                       err_abort;
    logic [CNT_W-1:0]           bit_cnt;

    modport master (
        output data_en,
        output data,
        input  duty,
        input  out_en,
        input  frame_ok,
        input  err_parity,
        input  err_abort,
        input  bit_cnt
    );

    modport slave (
        input  data_en,
        input  data,
        output duty,
        output out_en,
        output frame_ok,
        output err_parity,
        output err_abort,
        output bit_cnt
    );
endinterface

// File: rtl/serial_duty_receiver.sv
// Addressed, parity-protected serial receiver for multi-channel PWM duty words.
// A full valid frame commits the duty bus and enable atomically on its final bit.
module serial_duty_receiver #(
    parameter int                CHANNELS = 3,
    parameter int                DUTY_W   = 10,
    parameter int                ADDR_W   = 4,
    parameter logic [ADDR_W-1:0] DEV_ADDR = 4'h1
) (
    input  logic                  clock_data,
    input  logic                  reset,
    serial_duty_receiver_if.slave bus
);
    localparam int FRAME_LEN = ADDR_W + 2 + CHANNELS * DUTY_W + 1;
    localparam int PAY_W     = FRAME_LEN - 1;
    localparam int DW        = CHANNELS * DUTY_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_q, par_d;
    logic [PAY_W-1:0]  sreg_q, sreg_d;
    logic [DW-1:0]     duty_q, duty_d;
    logic              en_q, en_d;
    logic              ok_q, ok_d;
    logic              perr_q, perr_d;
    logic              abrt_q, abrt_d;

    logic [ADDR_W-1:0] addr;
    logic [1:0]        cmd;
    logic [DW-1:0]     payload;
    logic              last;
    logic              addr_hit;

    // Shifting right leaves frame bit 0 at sreg_q[0] once all non-parity bits are in.
    assign addr     = sreg_q[ADDR_W-1:0];
    assign cmd      = sreg_q[ADDR_W+1:ADDR_W];
    assign payload  = sreg_q[ADDR_W+2 +: DW];
    assign last     = (state_q == RECV) && (cnt_q == CNT_W'(FRAME_LEN - 1));
    assign addr_hit = (addr == DEV_ADDR) || (addr == {ADDR_W{1'b1}});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        sreg_d  = sreg_q;
        duty_d  = duty_q;
        en_d    = en_q;
        ok_d    = 1'b0;
        perr_d  = 1'b0;
        abrt_d  = 1'b0;

        unique case (1'b1)
            (bus.data_en && last): begin
                state_d = IDLE;
                cnt_d   = '0;
                par_d   = 1'b0;
                if (par_q ^ bus.data) begin
                    perr_d = 1'b1;
                end else if (addr_hit) begin
                    case (cmd)
                        2'b00: begin
                            duty_d = payload;
                            ok_d   = 1'b1;
                        end
                        2'b01: begin
                            duty_d = payload;
                            en_d   = 1'b1;
                            ok_d   = 1'b1;
                        end
                        2'b10: begin
                            duty_d = '0;
                            en_d   = 1'b0;
                            ok_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            (bus.data_en && !last): begin
                state_d = RECV;
                sreg_d  = {bus.data, sreg_q[PAY_W-1:1]};
                cnt_d   = cnt_q + 1'b1;
                par_d   = par_q ^ bus.data;
            end
            (!bus.data_en && state_q == RECV): begin
                state_d = IDLE;
                cnt_d   = '0;
                par_d   = 1'b0;
                abrt_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_data or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            sreg_q  <= '0;
            duty_q  <= '0;
            en_q    <= 1'b0;
            ok_q    <= 1'b0;
            perr_q  <= 1'b0;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            sreg_q  <= sreg_d;
            duty_q  <= duty_d;
            en_q    <= en_d;
            ok_q    <= ok_d;
            perr_q  <= perr_d;
            abrt_q  <= abrt_d;
        end
    end

    assign bus.duty       = duty_q;
    assign bus.out_en     = en_q;
    assign bus.frame_ok   = ok_q;
    assign bus.err_parity = perr_q;
    assign bus.err_abort  = abrt_q;
    assign bus.bit_cnt    = cnt_q;
endmodule
